// File: rtl/delay_chain_probe_if.sv
// Bundle of chain inputs, tap outputs and latency-meter results for delay_chain_probe.
interface delay_chain_probe_if #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8,
    parameter int TAP_W    = $clog2(DEPTH)
);
    logic [CHANNELS-1:0] din;
    logic [1:0]          mode;
    logic [TAP_W-1:0]    tap_sel;
    logic                meas_start;
    logic [CHANNELS-1:0] tap_out;
    logic [CHANNELS-1:0] last_out;
    logic                meas_busy;
    logic                meas_valid;
    logic                meas_timeout;
    logic [CNT_W-1:0]    meas_count;

    modport master (
        output din, mode, tap_sel, meas_start,
        input  tap_out, last_out, meas_busy, meas_valid, meas_timeout, meas_count
    );

    modport slave (
        input  din, mode, tap_sel, meas_start,
        output tap_out, last_out, meas_busy, meas_valid, meas_timeout, meas_count
    );
endinterface

// File: rtl/delay_chain_probe.sv
// Multi-channel registered delay/inversion/ring chains with a tap-change latency meter
// that watches channel 0 at the selected tap.
module delay_chain_probe #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 8,
    parameter int TAP_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    delay_chain_probe_if.slave    bus
);
    localparam logic [1:0] MODE_BUF  = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_RING = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } meter_state_t;

    logic [DEPTH-1:0]    chain_r [CHANNELS];
    logic [TAP_W-1:0]    tap_idx_s;
    logic [CHANNELS-1:0] tap_s;
    logic [CHANNELS-1:0] last_s;

    meter_state_t        state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                ref_r, ref_s;
    logic [CNT_W-1:0]    count_r, count_s;
    logic                timeout_r, timeout_s;

    // Chain stages: shift, shift-with-inversion, Johnson ring or hold per mode.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                chain_r[c] <= {DEPTH{1'b0}};
            end else begin
                case (bus.mode)
                    MODE_BUF:  chain_r[c] <= {chain_r[c][DEPTH-2:0], bus.din[c]};
                    MODE_INV:  chain_r[c] <= {~chain_r[c][DEPTH-2:0], ~bus.din[c]};
                    MODE_RING: chain_r[c] <= {chain_r[c][DEPTH-2:0], ~chain_r[c][DEPTH-1]};
                    MODE_HOLD: chain_r[c] <= chain_r[c];
                    default:   chain_r[c] <= chain_r[c];
                endcase
            end
        end
    end

    // Out-of-range tap selects (non power-of-two DEPTH) clamp to the last stage.
    always_comb begin
        tap_idx_s = bus.tap_sel;
        if (32'(bus.tap_sel) >= 32'(DEPTH)) begin
            tap_idx_s = TAP_W'(DEPTH - 1);
        end else begin
            tap_idx_s = bus.tap_sel;
        end
    end

    // Tap and last-stage reads straight from the stage registers.
    always_comb begin
        tap_s  = {CHANNELS{1'b0}};
        last_s = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            tap_s[c]  = chain_r[c][tap_idx_s];
            last_s[c] = chain_r[c][DEPTH-1];
        end
    end

    // Meter register bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            ref_r     <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            ref_r     <= ref_s;
            count_r   <= count_s;
            timeout_r <= timeout_s;
        end
    end

    // Meter next-state: a start always re-arms, even when it coincides with a detection.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        ref_s     = ref_r;
        count_s   = count_r;
        timeout_s = timeout_r;
        if (bus.meas_start) begin
            state_s   = ST_RUN;
            cnt_s     = {CNT_W{1'b0}};
            ref_s     = tap_s[0];
            count_s   = {CNT_W{1'b0}};
            timeout_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_IDLE;
                ST_RUN: begin
                    if (tap_s[0] != ref_r) begin
                        count_s   = cnt_r + CNT_W'(1);
                        timeout_s = 1'b0;
                        state_s   = ST_DONE;
                    end else if ((cnt_r + CNT_W'(1)) == CNT_MAX) begin
                        count_s   = CNT_MAX;
                        timeout_s = 1'b1;
                        state_s   = ST_DONE;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    assign bus.tap_out      = tap_s;
    assign bus.last_out     = last_s;
    assign bus.meas_busy    = (state_r == ST_RUN);
    assign bus.meas_valid   = (state_r == ST_DONE);
    assign bus.meas_timeout = timeout_r;
    assign bus.meas_count   = count_r;
endmodule

// File: tb/tb_delay_chain_probe.sv
// Directed and random checks of delay_chain_probe against a timestamp-based reference model.
module tb_delay_chain_probe;
    localparam int CH = 4;
    localparam int D  = 8;
    localparam int CW = 8;
    localparam int TW = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    delay_chain_probe_if #(.CHANNELS(CH), .DEPTH(D), .CNT_W(CW), .TAP_W(TW)) bus ();

    delay_chain_probe #(.CHANNELS(CH), .DEPTH(D), .CNT_W(CW), .TAP_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: stage bits per channel, and a meter based on edge timestamps.
    bit m_chain [CH][D];
    int m_state;      // 0 idle, 1 running, 2 done
    bit m_ref;
    int m_t0;
    int m_count;
    bit m_timeout;
    int cyc = 0;

    function automatic int tap_idx(input logic [TW-1:0] sel);
        return (int'(sel) >= D) ? D - 1 : int'(sel);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < D; k++) m_chain[c][k] = 1'b0;
        m_state = 0; m_ref = 1'b0; m_t0 = 0; m_count = 0; m_timeout = 1'b0;
    endtask

    task automatic tick();
        bit nxt [CH][D];
        bit tap0;
        int el;
        tap0 = m_chain[0][tap_idx(bus.tap_sel)];
        if (rst) begin
            model_reset();
        end else begin
            if (bus.meas_start) begin
                m_state = 1; m_ref = tap0; m_t0 = cyc; m_count = 0; m_timeout = 1'b0;
            end else if (m_state == 1) begin
                el = cyc - m_t0;
                if (tap0 != m_ref) begin
                    m_count = el; m_timeout = 1'b0; m_state = 2;
                end else if (el == CMAX) begin
                    m_count = CMAX; m_timeout = 1'b1; m_state = 2;
                end
            end
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < D; k++) begin
                    case (bus.mode)
                        2'd0: nxt[c][k] = (k == 0) ? bus.din[c] : m_chain[c][k-1];
                        2'd1: nxt[c][k] = (k == 0) ? ~bus.din[c] : ~m_chain[c][k-1];
                        2'd2: nxt[c][k] = (k == 0) ? ~m_chain[c][D-1] : m_chain[c][k-1];
                        default: nxt[c][k] = m_chain[c][k];
                    endcase
                end
            end
            m_chain = nxt;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string tag);
        logic [CH-1:0] e_tap, e_last;
        for (int c = 0; c < CH; c++) begin
            e_tap[c]  = m_chain[c][tap_idx(bus.tap_sel)];
            e_last[c] = m_chain[c][D-1];
        end
        chk({tag, ".tap_out"},  32'(bus.tap_out),      32'(e_tap));
        chk({tag, ".last_out"}, 32'(bus.last_out),     32'(e_last));
        chk({tag, ".busy"},     32'(bus.meas_busy),    32'(m_state == 1));
        chk({tag, ".valid"},    32'(bus.meas_valid),   32'(m_state == 2));
        chk({tag, ".timeout"},  32'(bus.meas_timeout), 32'(m_timeout));
        chk({tag, ".count"},    32'(bus.meas_count),   32'(m_count));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.din  = 4'($urandom);
            bus.mode = 2'($urandom);
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        bus.din = 4'h0; bus.mode = 2'd0; bus.tap_sel = 3'd0; bus.meas_start = 1'b0;

        // Reset with random inputs
        do_reset(2);
        check_all("reset");
        chk("reset.tap_zero", 32'(bus.tap_out), 32'h0);
        bus.mode = 2'd0; bus.din = 4'h0;
        for (int i = 0; i < 4; i++) begin tick(); check_all("buf_idle"); end
        chk("buf_idle.tap_zero", 32'(bus.tap_out), 32'h0);

        // BUF latency through tap 7
        bus.tap_sel = 3'd7; bus.meas_start = 1'b1; bus.din = 4'h1;
        tick(); bus.meas_start = 1'b0;
        check_all("buf_start");
        for (int i = 0; i < 9; i++) begin tick(); check_all("buf_lat"); end
        chk("buf_lat.count8", 32'(bus.meas_count), 32'd8);
        chk("buf_lat.valid", 32'(bus.meas_valid), 32'd1);

        // INV: stage 0 of a zero input is 1, stage 1 is 0
        do_reset(1);
        bus.mode = 2'd1; bus.din = 4'h0; bus.tap_sel = 3'd0;
        for (int i = 0; i < 10; i++) begin tick(); check_all("inv"); end
        chk("inv.tap0_ones", 32'(bus.tap_out), 32'hF);
        bus.tap_sel = 3'd1; #1;
        check_all("inv_tap1");
        chk("inv.tap1_zeros", 32'(bus.tap_out), 32'h0);

        // RING from reset, start on first ring cycle
        do_reset(1);
        bus.mode = 2'd2; bus.tap_sel = 3'd7; bus.meas_start = 1'b1;
        tick(); bus.meas_start = 1'b0;
        for (int i = 0; i < 40; i++) begin tick(); check_all("ring"); end
        chk("ring.count8", 32'(bus.meas_count), 32'd8);

        // Timeout in HOLD
        bus.mode = 2'd3; bus.meas_start = 1'b1;
        tick(); bus.meas_start = 1'b0;
        for (int i = 0; i < CMAX - 1; i++) begin
            tick();
            chk("hold.busy", 32'(bus.meas_busy), 32'(m_state == 1));
        end
        chk("hold.still_busy", 32'(bus.meas_busy), 32'd1);
        tick();
        check_all("timeout");
        chk("timeout.count", 32'(bus.meas_count), 32'd255);
        chk("timeout.flag", 32'(bus.meas_timeout), 32'd1);

        // Restart mid-run: result is relative to the second start
        do_reset(1);
        bus.mode = 2'd0; bus.tap_sel = 3'd7; bus.din = 4'h1; bus.meas_start = 1'b1;
        tick(); bus.meas_start = 1'b0;
        for (int i = 0; i < 2; i++) tick();
        bus.meas_start = 1'b1; tick(); bus.meas_start = 1'b0;
        for (int i = 0; i < 7; i++) begin tick(); check_all("restart"); end
        chk("restart.count5", 32'(bus.meas_count), 32'd5);

        // Reset mid-run aborts
        bus.din = 4'h0; bus.meas_start = 1'b1; tick(); bus.meas_start = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_all("abort");
        chk("abort.busy", 32'(bus.meas_busy), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.din        = 4'($urandom);
            bus.mode       = 2'($urandom_range(0, 3));
            bus.tap_sel    = 3'($urandom);
            bus.meas_start = ($urandom_range(0, 11) == 0);
            rst            = ($urandom_range(0, 79) == 0);
            tick();
            check_all("rand");
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/delay_chain_probe.md
# delay_chain_probe

Parametrised, multi-channel, fully synchronous delay/inversion chain with a built-in latency meter. It generalises the fixed three-stage inverter chain to CHANNELS independent chains of DEPTH registered stages. Each chain runs in one of four modes: buffer, invert, ring, or hold. A selectable tap drives the outputs, and the meter measures the cycles from a start pulse until channel 0's tap changes. It sits behind the tt_um top-level wrapper, between the ui_in/uo_out pins and the design.

## Interface
- CHANNELS, default 4: number of independent chains.
- DEPTH, default 8: stages per chain. Minimum 2.
- CNT_W, default 8: latency counter width.
- TAP_W, default $clog2(DEPTH): tap select width.
- clk, input, 1: single clock; all state changes on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- din, input, CHANNELS: chain inputs, one per channel.
- mode, input, 2: 0 BUF, 1 INV, 2 RING, 3 HOLD.
- tap_sel, input, TAP_W: stage index routed to tap_out.
- meas_start, input, 1: single-cycle pulse that starts a measurement.
- tap_out, output, CHANNELS: tap_out[c] = s[c][tap_sel].
- last_out, output, CHANNELS: last_out[c] = s[c][DEPTH-1].
- meas_busy, output, 1: high while the meter state is RUN.
- meas_valid, output, 1: high while the meter state is DONE.
- meas_timeout, output, 1: the DONE result saturated without detecting a change.
- meas_count, output, CNT_W: measured latency in clk cycles.

## Operation
- Chain state: register s[c][k], for c < CHANNELS and k < DEPTH. Per-edge update by mode:
  - BUF: s[c][0] <= din[c]; s[c][k] <= s[c][k-1].
  - INV: s[c][0] <= ~din[c]; s[c][k] <= ~s[c][k-1]. Stage k therefore carries din inverted k+1 times, delayed k+1 cycles.
  - RING: s[c][0] <= ~s[c][DEPTH-1]; s[c][k] <= s[c][k-1]. This is a Johnson counter with period 2*DEPTH cycles; din is ignored.
  - HOLD: all stages keep their value.
- Mode changes take effect on the next edge. Chain contents are never cleared by a mode change.
- tap_sel >= DEPTH (possible when DEPTH is not a power of two) clamps to DEPTH-1.
- tap_out and last_out are combinational reads of registers; there is no added latency.
- Meter FSM states: IDLE, RUN, DONE.
  - Any state, meas_start=1 on an edge: ref <= tap_out[0], cnt <= 0, state <= RUN. This also restarts an ongoing RUN and clears DONE outputs.
  - RUN, tap_out[0] != ref: meas_count <= cnt+1, meas_timeout <= 0, state <= DONE.
  - RUN, no change, cnt+1 == 2^CNT_W-1: meas_count <= 2^CNT_W-1, meas_timeout <= 1, state <= DONE.
  - RUN otherwise: cnt <= cnt+1.
  - DONE: holds meas_count and meas_timeout until the next meas_start.
- The meter always observes channel 0 at the current tap_sel. tap_sel changes during RUN are legal; a resulting tap change counts as detection.

## Timing
- Reset, synchronous, takes priority over all else:
  - every s[c][k] = 0, so tap_out = 0 and last_out = 0;
  - meter state IDLE, cnt = 0, ref = 0;
  - meas_busy = 0, meas_valid = 0, meas_timeout = 0, meas_count = 0.
- Reset asserted mid-RUN aborts the measurement; no result is produced.
- Chain latency in BUF/INV: a din change sampled at edge t appears on tap_out after edge t+tap_sel.
- Meter: start at edge t0 with din[0] toggled in the same cycle, BUF mode gives meas_count = tap_sel+1.
- meas_busy rises after the start edge. meas_valid rises after the detection edge, and meas_busy falls on that same edge.
- Worst-case RUN length: 2^CNT_W-1 edges.
- Simultaneous meas_start and detection: the start wins; the meter re-arms with the new ref.
- HOLD during RUN: the tap cannot change, so the run ends in timeout unless mode or tap_sel changes.

## Test plan
- Reset: hold rst=1 for 2 cycles with random din and mode -> all outputs 0 and meter IDLE; release, mode=BUF, din=0 -> tap_out stays 0.
- BUF latency, DEPTH=8, tap_sel=7: pulse meas_start and set din[0]=1 in the same cycle -> tap_out[0]=1 after 8 edges; meas_valid=1 with meas_count=8 and meas_timeout=0.
- INV: after reset, mode=INV, din=0 held for 10 cycles, tap_sel=0 -> tap_out = all ones; tap_sel=1 -> tap_out = all zeros.
- RING, DEPTH=8, from reset, tap_sel=7: meas_start on the first RING cycle -> meas_count=8; tap_out[0] then toggles every 8 cycles (period 16).
- Timeout, CNT_W=8: mode=HOLD, meas_start -> meas_busy for 255 edges; then meas_valid=1, meas_timeout=1, meas_count=255.
- Restart and abort:
  - meas_start again mid-RUN -> cnt restarts from 0 and the result is relative to the second start;
  - rst asserted mid-RUN -> meas_busy=0, meas_valid=0, meas_count=0.
